// File: rtl/fpu_defs_fmac.sv
// fpu_defs_fmac: shared constants and types for the FMAC output stage
package fpu_defs_fmac;
    localparam int C_MANT      = 23;
    localparam int C_EXP       = 8;
    localparam int C_RM        = 3;
    localparam int C_TAG_WIDTH = 4;

    localparam logic [C_RM-1:0] C_RM_NEAREST  = 3'd0;
    localparam logic [C_RM-1:0] C_RM_TRUNC    = 3'd1;
    localparam logic [C_RM-1:0] C_RM_MINUSINF = 3'd2;
    localparam logic [C_RM-1:0] C_RM_PLUSINF  = 3'd3;

    localparam int C_FLAG_NX = 0;
    localparam int C_FLAG_UF = 1;
    localparam int C_FLAG_OF = 2;
    localparam int C_FLAG_DZ = 3;
    localparam int C_FLAG_NV = 4;

    localparam logic [31:0] C_QNAN_32   = 32'h7FC0_0000;
    localparam logic [30:0] C_MAXFIN_32 = 31'h7F7F_FFFF;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    typedef struct packed {
        logic [31:0]            result;
        logic [4:0]             flags;
        logic [C_TAG_WIDTH-1:0] tag;
    } fmac_out_t;
endpackage

// File: rtl/fpu_out_fmac_if.sv
// fpu_out_fmac_if: upstream and downstream handshake/data bundle of the FMAC output stage
interface fpu_out_fmac_if;
    import fpu_defs_fmac::*;
    logic                   Valid_SI;
    logic                   Ready_SO;
    logic [C_MANT-1:0]      Mant_res_DI;
    logic [C_EXP-1:0]       Exp_res_DI;
    logic                   Sign_res_DI;
    logic                   Exp_OF_SI;
    logic                   Exp_UF_SI;
    logic                   Flag_Inexact_SI;
    logic                   Special_SI;
    logic                   Invalid_SI;
    logic [C_RM-1:0]        RM_SI;
    logic [C_TAG_WIDTH-1:0] Tag_DI;
    logic                   Valid_SO;
    logic                   Ready_SI;
    logic [31:0]            Result_DO;
    logic [4:0]             Flags_DO;
    logic [C_TAG_WIDTH-1:0] Tag_DO;

    modport master (
        output Valid_SI, Mant_res_DI, Exp_res_DI, Sign_res_DI, Exp_OF_SI, Exp_UF_SI,
               Flag_Inexact_SI, Special_SI, Invalid_SI, RM_SI, Tag_DI, Ready_SI,
        input  Ready_SO, Valid_SO, Result_DO, Flags_DO, Tag_DO
    );
    modport slave (
        input  Valid_SI, Mant_res_DI, Exp_res_DI, Sign_res_DI, Exp_OF_SI, Exp_UF_SI,
               Flag_Inexact_SI, Special_SI, Invalid_SI, RM_SI, Tag_DI, Ready_SI,
        output Ready_SO, Valid_SO, Result_DO, Flags_DO, Tag_DO
    );
endinterface

// File: rtl/fpu_fmac_skid.sv
// fpu_fmac_skid: generic 2-entry FIFO skid buffer with registered ready and head data
module fpu_fmac_skid
    import fpu_defs_fmac::*;
#(
    parameter type T = fmac_out_t
) (
    input  logic Clk_CI,
    input  logic Rst_RBI,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    occ_t state;
    T     skid;
    logic push;
    logic pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state != EMPTY);

    // Occupancy FSM: head register drives the outputs, skid holds the second entry
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            out_data <= '0;
            skid     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_data <= in_data;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_data <= in_data;
                    end else if (push) begin
                        skid     <= in_data;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        out_data <= skid;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/fpu_out_fmac.sv
// fpu_out_fmac: FMAC output stage - overflow correction, binary32 packing, flags, skid buffer
// Optional sticky flag accumulator enabled by defining FPU_FMAC_FFLAGS_EN.
module fpu_out_fmac
    import fpu_defs_fmac::*;
(
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    fpu_out_fmac_if.slave     bus,
    input  logic              FFlags_clr_SI,
    output logic [4:0]        FFlags_DO
);
    fmac_out_t packed_d;
    fmac_out_t head_q;
    logic      ovf;
    logic      sat;
    logic      pop;

    assign ovf = bus.Exp_OF_SI & ~bus.Special_SI;
    assign sat = ovf & ((bus.RM_SI == C_RM_TRUNC) |
                        ((bus.RM_SI == C_RM_PLUSINF) & bus.Sign_res_DI) |
                        ((bus.RM_SI == C_RM_MINUSINF) & ~bus.Sign_res_DI));

    // Pack the result word and derive this op's exception flags
    always_comb begin
        packed_d        = '0;
        packed_d.result = sat ? {bus.Sign_res_DI, C_MAXFIN_32} :
                          ((bus.Exp_res_DI == 8'hFF) && (bus.Mant_res_DI != '0)) ? C_QNAN_32 :
                          {bus.Sign_res_DI, bus.Exp_res_DI, bus.Mant_res_DI};
        packed_d.flags[C_FLAG_NV] = bus.Invalid_SI;
        packed_d.flags[C_FLAG_DZ] = 1'b0;
        packed_d.flags[C_FLAG_OF] = ovf;
        packed_d.flags[C_FLAG_UF] = bus.Exp_UF_SI & bus.Flag_Inexact_SI & ~bus.Special_SI;
        packed_d.flags[C_FLAG_NX] = (bus.Flag_Inexact_SI | ovf) & ~bus.Special_SI;
        packed_d.tag              = bus.Tag_DI;
    end

    fpu_fmac_skid #(.T(fmac_out_t)) i_skid (
        .Clk_CI    (Clk_CI),
        .Rst_RBI   (Rst_RBI),
        .in_valid  (bus.Valid_SI),
        .in_ready  (bus.Ready_SO),
        .in_data   (packed_d),
        .out_valid (bus.Valid_SO),
        .out_ready (bus.Ready_SI),
        .out_data  (head_q)
    );

    assign pop           = bus.Valid_SO & bus.Ready_SI;
    assign bus.Result_DO = head_q.result;
    assign bus.Flags_DO  = head_q.flags;
    assign bus.Tag_DO    = head_q.tag;

`ifdef FPU_FMAC_FFLAGS_EN
    // Sticky flags: clear takes effect first so flags popped in the same cycle survive
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            FFlags_DO <= '0;
        end else if (FFlags_clr_SI) begin
            FFlags_DO <= pop ? head_q.flags : 5'b0;
        end else if (pop) begin
            FFlags_DO <= FFlags_DO | head_q.flags;
        end
    end
`else
    logic unused_fflags;
    assign unused_fflags = FFlags_clr_SI ^ pop;
    assign FFlags_DO     = '0;
`endif
endmodule
